sys_onchip_mem_arbiter: RTL and testbench
=========================================

# sys_onchip_mem_arbiter

Two-master arbiter that shares the single-port on-chip RAM (1024 × 32, byte-enabled, one-cycle read latency) between two Avalon-MM requesters. It sits between the masters and the RAM's `s1` port. It grants one access per cycle, holds waitrequest on the loser, and steers read data back with a `readdatavalid` pulse. It also sequences the RAM's clock-enable and reset-request around system reset.

## Interface
- `ADDR_W`, 10: word address width.
- `DATA_W`, 32: data width.
- `BE_W`, `DATA_W/8`: byteenable width.
- `HOLD_MAX`, 4: maximum consecutive grants to one master while the other waits (≥1).

- `clk`  in  1: single clock.
- `reset_n`  in  1: reset, **asynchronous assert, active-low**.
- `m0_address`/`m1_address`  in  ADDR_W: word address.
- `m0_byteenable`/`m1_byteenable`  in  BE_W: byte lanes.
- `m0_read`/`m1_read`  in  1: read request.
- `m0_write`/`m1_write`  in  1: write request.
- `m0_writedata`/`m1_writedata`  in  DATA_W: write data.
- `m0_waitrequest`/`m1_waitrequest`  out  1: request not accepted this cycle.
- `m0_readdata`/`m1_readdata`  out  DATA_W: read data.
- `m0_readdatavalid`/`m1_readdatavalid`  out  1: read data valid.
- `mem_address`  out  ADDR_W: to RAM `address`.
- `mem_byteenable`  out  BE_W: to RAM `byteenable`.
- `mem_chipselect`  out  1: to RAM `chipselect`.
- `mem_write`  out  1: to RAM `write`.
- `mem_writedata`  out  DATA_W: to RAM `writedata`.
- `mem_clken`  out  1: to RAM `clken`.
- `mem_reset_req`  out  1: to RAM `reset_req`.
- `mem_readdata`  in  DATA_W: from RAM `readdata`.

## Operation
- **Request.** `mX_req = mX_read | mX_write`. Read and write asserted together in the same cycle is illegal: the arbiter treats it as a write. The bench flags it.
- **Reset sequencing.**
  - A 2-flop synchronizer on `reset_n` produces `rst_done`.
  - `mem_reset_req = ~rst_done`.
  - `mem_clken = 1` constantly.
  - While `mem_reset_req` = 1, nothing is granted and both waitrequests are 1.
- **Arbiter state.** Registered `owner` (NONE/M0/M1), `last` (M0/M1, reset M1) and `hold_cnt` (log2(HOLD_MAX)+1 bits, reset 0).
- **Winner selection** (combinational, same cycle):
  - One requester: that master wins.
  - Both request, owner = X, `hold_cnt < HOLD_MAX-1`: X keeps the grant.
  - Both request otherwise: the master ≠ `last` wins.
- **Grant.**
  - The winner's address, byteenable and writedata are muxed to `mem_*`.
  - `mem_chipselect = 1` (reads included); `mem_write` = the winner's write.
  - Winner waitrequest = 0; loser waitrequest = 1.
  - When nobody wins: `mem_chipselect = 0`, `mem_write = 0`, and both waitrequests are 0. Idle waitrequest carries no meaning.
- **State update at the clock edge.**
  - Winner = owner: `hold_cnt++`, saturating.
  - Winner ≠ owner: `hold_cnt = 0`, `owner = winner`.
  - Any grant: `last = winner`.
  - No request: `owner = NONE`, `hold_cnt = 0`.
- **Read return.**
  - A granted read sets `rd_pend = 1` and `rd_own = winner`; otherwise `rd_pend = 0`.
  - Next cycle, `mX_readdatavalid = rd_pend & (rd_own == X)`.
  - Both `mX_readdata` are driven from `mem_readdata` directly.
- **Back-to-back operation.** Pipelined reads sustain 1 read/cycle. A write accepted the cycle after a read does not disturb that read's return.
- **Reset mid-operation.** An in-flight read is dropped: `rd_pend` clears and no `readdatavalid` is produced. Hold state clears. `m0` wins first after reset.

## Timing
- Grant latency: 0 cycles (waitrequest is combinational from requests and state).
- Read latency: request accepted at edge N → `readdatavalid` and data in cycle N+1.
- Write: committed at the accepting edge.
- **Reset values:**
  - All waitrequests are 1 during reset and for 2 cycles after `reset_n` rises.
  - `readdatavalid` = 0, `mem_chipselect` = 0, `mem_write` = 0.
  - `mem_reset_req` = 1, `mem_clken` = 1.
  - `mem_address`, `mem_byteenable` and `mem_writedata` = 0.
  - `readdata` passes `mem_readdata` through.
- Worst-case wait for a continuously requesting master: HOLD_MAX cycles (round-robin build only).

## Configuration
- `MEMARB_ROUND_ROBIN_EN` defined: round-robin with HOLD_MAX hold, exactly as above.
- `MEMARB_ROUND_ROBIN_EN` undefined: fixed priority.
  - m0 wins whenever it requests; m1 wins only when m0 is idle.
  - `hold_cnt` and `last` are not implemented.
  - m1 may starve.

## Test plan
- **Reset release:** deassert `reset_n` with both masters requesting → both waitrequests stay 1 for exactly 2 cycles, `mem_reset_req` falls on cycle 2, and m0 is granted first.
- **Single-master write/read:** m0 writes 0xDEADBEEF to address 0x3FF with BE=0xF, then reads 0x3FF → `m0_readdatavalid` pulses 1 cycle after acceptance with 0xDEADBEEF; `m1_readdatavalid` stays 0.
- **Contention (round-robin, HOLD_MAX=4):** both masters issue continuous reads → grant pattern is m0×4, m1×4, m0×4, … and each readdatavalid is routed to its issuer.
- **Byte enables:** m1 writes 0x11223344 to address 5 with BE=0x5, after address 5 holds 0xFFFFFFFF → a read of 5 returns 0xFF22FF44.
- **Reset mid-read:** assert `reset_n` = 0 in the cycle after m0's read is accepted → no `readdatavalid` occurs, and outputs match reset values immediately (asynchronous).
- **Fixed priority (macro undefined):** both masters request for 10 cycles → m1 waitrequest = 1 throughout; m1 is granted in the first cycle m0 drops its request.

Source files
------------

// File: rtl/sys_onchip_mem_arbiter.sv
// Two-master Avalon-MM arbiter in front of a single-port 1-cycle-latency on-chip RAM.
// Macro MEMARB_ROUND_ROBIN_EN selects round-robin with HOLD_MAX hold; otherwise m0 has fixed priority.
module sys_onchip_mem_arbiter #(
   parameter int ADDR_W   = 10,
   parameter int DATA_W   = 32,
   parameter int BE_W     = DATA_W / 8,
   parameter int HOLD_MAX = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic [BE_W-1:0]   m0_byteenable,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic [BE_W-1:0]   m1_byteenable,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
   output logic [ADDR_W-1:0] mem_address,
   output logic [BE_W-1:0]   mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_writedata,
   output logic              mem_clken,
   output logic              mem_reset_req,
   input  logic [DATA_W-1:0] mem_readdata
);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_M0   = 2'd1,
      OWN_M1   = 2'd2
   } owner_e;

   logic [1:0] rst_sync_r;
   logic       rst_done_s;
   logic       req0_s;
   logic       req1_s;
   owner_e     winner_s;
   logic       rd_pend_r;
   logic       rd_pend_nxt_s;
   logic       rd_own_r;      // 1'b1 = the pending read belongs to m1
   logic       rd_own_nxt_s;

`ifdef MEMARB_ROUND_ROBIN_EN
   localparam int              HC_W      = $clog2(HOLD_MAX) + 1;
   localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_MAX - 1);
   owner_e          owner_r;
   owner_e          owner_nxt_s;
   owner_e          last_r;
   owner_e          last_nxt_s;
   logic [HC_W-1:0] hold_cnt_r;
   logic [HC_W-1:0] hold_cnt_nxt_s;
`endif

   if (HOLD_MAX < 1) begin : g_hold_max_chk
      $error("HOLD_MAX must be at least 1");
   end

   assign req0_s        = m0_read | m0_write;
   assign req1_s        = m1_read | m1_write;
   assign rst_done_s    = rst_sync_r[1];
   assign mem_reset_req = ~rst_done_s;
   assign mem_clken     = 1'b1;

   assign m0_readdata      = mem_readdata;
   assign m1_readdata      = mem_readdata;
   assign m0_readdatavalid = rd_pend_r & ~rd_own_r;
   assign m1_readdatavalid = rd_pend_r & rd_own_r;

   // Reset synchronizer: asynchronous assert, release two edges after reset_n rises.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rst_sync_r <= 2'b00;
      end else begin
         rst_sync_r <= {rst_sync_r[0], 1'b1};
      end
   end

   // Winner selection for the current cycle.
   always_comb begin
      winner_s = OWN_NONE;
      if (!rst_done_s) begin
         winner_s = OWN_NONE;
      end else if (req0_s && !req1_s) begin
         winner_s = OWN_M0;
      end else if (!req0_s && req1_s) begin
         winner_s = OWN_M1;
      end else if (req0_s && req1_s) begin
`ifdef MEMARB_ROUND_ROBIN_EN
         if ((owner_r != OWN_NONE) && (hold_cnt_r < HOLD_LAST)) begin
            winner_s = owner_r;
         end else if (last_r == OWN_M0) begin
            winner_s = OWN_M1;
         end else begin
            winner_s = OWN_M0;
         end
`else
         winner_s = OWN_M0;
`endif
      end else begin
         winner_s = OWN_NONE;
      end
   end

   // Next-state logic: hold/ownership bookkeeping and read-return tracking.
   always_comb begin
      rd_pend_nxt_s = 1'b0;
      rd_own_nxt_s  = rd_own_r;
      case (winner_s)
         OWN_M0: begin
            rd_pend_nxt_s = m0_read & ~m0_write;
            rd_own_nxt_s  = 1'b0;
         end
         OWN_M1: begin
            rd_pend_nxt_s = m1_read & ~m1_write;
            rd_own_nxt_s  = 1'b1;
         end
         default: begin
            rd_pend_nxt_s = 1'b0;
            rd_own_nxt_s  = rd_own_r;
         end
      endcase
`ifdef MEMARB_ROUND_ROBIN_EN
      owner_nxt_s    = owner_r;
      last_nxt_s     = last_r;
      hold_cnt_nxt_s = hold_cnt_r;
      if (winner_s == OWN_NONE) begin
         owner_nxt_s    = OWN_NONE;
         hold_cnt_nxt_s = {HC_W{1'b0}};
      end else if (winner_s == owner_r) begin
         last_nxt_s = winner_s;
         if (hold_cnt_r != {HC_W{1'b1}}) begin
            hold_cnt_nxt_s = hold_cnt_r + {{(HC_W-1){1'b0}}, 1'b1};
         end else begin
            hold_cnt_nxt_s = hold_cnt_r;
         end
      end else begin
         owner_nxt_s    = winner_s;
         last_nxt_s     = winner_s;
         hold_cnt_nxt_s = {HC_W{1'b0}};
      end
`endif
   end

   // State registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_pend_r  <= 1'b0;
         rd_own_r   <= 1'b0;
`ifdef MEMARB_ROUND_ROBIN_EN
         owner_r    <= OWN_NONE;
         last_r     <= OWN_M1;
         hold_cnt_r <= {HC_W{1'b0}};
`endif
      end else begin
         rd_pend_r  <= rd_pend_nxt_s;
         rd_own_r   <= rd_own_nxt_s;
`ifdef MEMARB_ROUND_ROBIN_EN
         owner_r    <= owner_nxt_s;
         last_r     <= last_nxt_s;
         hold_cnt_r <= hold_cnt_nxt_s;
`endif
      end
   end

   // Output steering: winner drives the RAM port, loser is stalled.
   always_comb begin
      mem_address    = {ADDR_W{1'b0}};
      mem_byteenable = {BE_W{1'b0}};
      mem_writedata  = {DATA_W{1'b0}};
      mem_chipselect = 1'b0;
      mem_write      = 1'b0;
      m0_waitrequest = ~rst_done_s;
      m1_waitrequest = ~rst_done_s;
      case (winner_s)
         OWN_M0: begin
            mem_address    = m0_address;
            mem_byteenable = m0_byteenable;
            mem_writedata  = m0_writedata;
            mem_chipselect = 1'b1;
            mem_write      = m0_write;
            m0_waitrequest = 1'b0;
            m1_waitrequest = 1'b1;
         end
         OWN_M1: begin
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_writedata  = m1_writedata;
            mem_chipselect = 1'b1;
            mem_write      = m1_write;
            m0_waitrequest = 1'b1;
            m1_waitrequest = 1'b0;
         end
         default: begin
            mem_chipselect = 1'b0;
            mem_write      = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_sys_onchip_mem_arbiter.sv
// Self-checking bench for sys_onchip_mem_arbiter: directed test-plan steps plus random traffic
// checked against a transaction-level model (shadow memory, grant streaks, read-return tracking).
module tb_sys_onchip_mem_arbiter;
   localparam int ADDR_W   = 10;
   localparam int DATA_W   = 32;
   localparam int BE_W     = 4;
   localparam int HOLD_MAX = 4;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [ADDR_W-1:0] m0_address, m1_address;
   logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
   logic              m0_read, m1_read, m0_write, m1_write;
   logic [DATA_W-1:0] m0_writedata, m1_writedata;
   logic              m0_waitrequest, m1_waitrequest;
   logic [DATA_W-1:0] m0_readdata, m1_readdata;
   logic              m0_readdatavalid, m1_readdatavalid;
   logic [ADDR_W-1:0] mem_address;
   logic [BE_W-1:0]   mem_byteenable;
   logic              mem_chipselect, mem_write, mem_clken, mem_reset_req;
   logic [DATA_W-1:0] mem_writedata, mem_readdata;

   always #5 clk = ~clk;

   sys_onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .HOLD_MAX(HOLD_MAX)) dut (
      .clk(clk), .reset_n(reset_n),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
      .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
      .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
      .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
      .mem_reset_req(mem_reset_req), .mem_readdata(mem_readdata)
   );

   // RAM behaviour: byte-enabled write at the edge, registered read data.
   logic [31:0] ram [0:1023];
   logic [31:0] ram_q;
   logic        ram_clear;
   assign mem_readdata = ram_q;
   always @(posedge clk) begin
      if (ram_clear) begin
         for (int i = 0; i < 1024; i++) ram[i] <= 32'h0;
      end else if (mem_chipselect && mem_write) begin
         for (int b = 0; b < 4; b++)
            if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else if (mem_chipselect) begin
         ram_q <= ram[mem_address];
      end
   end

   // Reference model state
   logic [31:0] shadow [0:1023];
   int          sync_cnt, prev_win, streak, last_win, exp_win, pend_who;
   bit          pend;
   logic [31:0] pend_data;
   int          total = 0, passes = 0, fails = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passes++;
      end else begin
         fails++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      sync_cnt = 0; prev_win = -1; streak = 0; last_win = 1; pend = 1'b0; exp_win = -1;
   endtask

   task automatic get_op(input int m, output logic rd, output logic wr, output logic [9:0] a,
                         output logic [3:0] be, output logic [31:0] d);
      if (m == 0) begin
         rd = m0_read; wr = m0_write; a = m0_address; be = m0_byteenable; d = m0_writedata;
      end else begin
         rd = m1_read; wr = m1_write; a = m1_address; be = m1_byteenable; d = m1_writedata;
      end
   endtask

   task automatic set_m(input int m, input logic rd, input logic wr, input logic [9:0] a,
                        input logic [3:0] be, input logic [31:0] d);
      if (m == 0) begin
         m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
      end else begin
         m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
      end
   endtask

   // Sample at the falling edge, predict this cycle's winner and compare every output.
   task automatic sample();
      logic r0, r1, blocked, rd, wr, w0, w1;
      logic [9:0] a; logic [3:0] be; logic [31:0] d;
      @(negedge clk);
      r0 = m0_read | m0_write;
      r1 = m1_read | m1_write;
      if (m0_read && m0_write) $display("note: m0 read+write together (illegal), treated as write");
      if (m1_read && m1_write) $display("note: m1 read+write together (illegal), treated as write");
      blocked = (sync_cnt < 2) || !reset_n;
      if (blocked || (!r0 && !r1)) exp_win = -1;
      else if (r0 && !r1) exp_win = 0;
      else if (!r0 && r1) exp_win = 1;
      else begin
`ifdef MEMARB_ROUND_ROBIN_EN
         if (prev_win >= 0 && streak < HOLD_MAX) exp_win = prev_win;
         else exp_win = 1 - last_win;
`else
         exp_win = 0;
`endif
      end
      if (exp_win >= 0) begin
         get_op(exp_win, rd, wr, a, be, d);
         w0 = (exp_win != 0); w1 = (exp_win != 1);
      end else begin
         rd = 1'b0; wr = 1'b0; a = 10'h0; be = 4'h0; d = 32'h0;
         w0 = blocked; w1 = blocked;
      end
      chk("m0_waitrequest", 32'(m0_waitrequest), 32'(w0));
      chk("m1_waitrequest", 32'(m1_waitrequest), 32'(w1));
      chk("mem_chipselect", 32'(mem_chipselect), 32'(exp_win >= 0));
      chk("mem_write", 32'(mem_write), 32'(wr));
      chk("mem_address", 32'(mem_address), 32'(a));
      chk("mem_byteenable", 32'(mem_byteenable), 32'(be));
      chk("mem_writedata", mem_writedata, d);
      chk("mem_reset_req", 32'(mem_reset_req), 32'(blocked));
      chk("mem_clken", 32'(mem_clken), 32'h1);
      chk("m0_readdatavalid", 32'(m0_readdatavalid), 32'(pend && pend_who == 0));
      chk("m1_readdatavalid", 32'(m1_readdatavalid), 32'(pend && pend_who == 1));
      chk("m0_readdata_pass", m0_readdata, mem_readdata);
      chk("m1_readdata_pass", m1_readdata, mem_readdata);
      if (pend) chk("read_return_data", (pend_who == 0) ? m0_readdata : m1_readdata, pend_data);
   endtask

   // Advance the model across the rising edge.
   task automatic tick();
      logic rd, wr; logic [9:0] a; logic [3:0] be; logic [31:0] d;
      @(posedge clk);
      if (reset_n) begin
         if (exp_win >= 0) begin
            get_op(exp_win, rd, wr, a, be, d);
            if (wr) begin
               for (int b = 0; b < 4; b++) if (be[b]) shadow[a][8*b +: 8] = d[8*b +: 8];
               pend = 1'b0;
            end else begin
               pend = 1'b1; pend_who = exp_win; pend_data = shadow[a];
            end
            streak   = (exp_win == prev_win) ? streak + 1 : 1;
            prev_win = exp_win;
            last_win = exp_win;
         end else begin
            pend = 1'b0; prev_win = -1; streak = 0;
         end
         if (sync_cnt < 2) sync_cnt++;
      end
      #1;
   endtask

   initial begin
      bit act0, act1;
      for (int i = 0; i < 1024; i++) shadow[i] = 32'h0;
      model_reset();
      ram_clear = 1'b1;
      set_m(0, 1'b1, 1'b0, 10'h001, 4'hF, 32'h0);
      set_m(1, 1'b1, 1'b0, 10'h002, 4'hF, 32'h0);
      repeat (3) begin sample(); tick(); end
      ram_clear = 1'b0;

      // Reset release with both masters requesting
      reset_n = 1'b1;
      sample(); chk("rel_c0_m0_wait", 32'(m0_waitrequest), 32'h1); chk("rel_c0_m1_wait", 32'(m1_waitrequest), 32'h1); tick();
      sample(); chk("rel_c1_m0_wait", 32'(m0_waitrequest), 32'h1); chk("rel_c1_reset_req", 32'(mem_reset_req), 32'h1); tick();
      sample(); chk("rel_c2_reset_req", 32'(mem_reset_req), 32'h0);
      chk("rel_first_grant_m0", 32'(m0_waitrequest), 32'h0); chk("rel_m1_stalled", 32'(m1_waitrequest), 32'h1); tick();
      set_m(0, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
      sample(); tick();
      set_m(1, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
      sample(); tick();

      // Single-master write then read
      set_m(0, 1'b0, 1'b1, 10'h3FF, 4'hF, 32'hDEADBEEF); sample(); tick();
      set_m(0, 1'b1, 1'b0, 10'h3FF, 4'hF, 32'h0);        sample(); tick();
      set_m(0, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0);          sample();
      chk("single_m0_rdv", 32'(m0_readdatavalid), 32'h1);
      chk("single_m0_data", m0_readdata, 32'hDEADBEEF);
      chk("single_m1_rdv", 32'(m1_readdatavalid), 32'h0);
      tick();

      // Byte enables
      set_m(1, 1'b0, 1'b1, 10'h005, 4'hF, 32'hFFFFFFFF); sample(); tick();
      set_m(1, 1'b0, 1'b1, 10'h005, 4'h5, 32'h11223344); sample(); tick();
      set_m(1, 1'b1, 1'b0, 10'h005, 4'hF, 32'h0);        sample(); tick();
      set_m(1, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0);          sample();
      chk("be_m1_rdv", 32'(m1_readdatavalid), 32'h1);
      chk("be_m1_data", m1_readdata, 32'hFF22FF44);
      tick();

`ifdef MEMARB_ROUND_ROBIN_EN
      // Contention: m0 x4, m1 x4, ...
      set_m(0, 1'b1, 1'b0, 10'h3FF, 4'hF, 32'h0);
      set_m(1, 1'b1, 1'b0, 10'h005, 4'hF, 32'h0);
      for (int i = 0; i < 16; i++) begin
         sample();
         chk("rr_m0_wait", 32'(m0_waitrequest), ((i / 4) % 2 == 0) ? 32'h0 : 32'h1);
         tick();
      end
`else
      // Fixed priority: m1 starves while m0 requests
      set_m(0, 1'b1, 1'b0, 10'h3FF, 4'hF, 32'h0);
      set_m(1, 1'b1, 1'b0, 10'h005, 4'hF, 32'h0);
      for (int i = 0; i < 10; i++) begin
         sample(); chk("fp_m1_wait", 32'(m1_waitrequest), 32'h1); tick();
      end
      set_m(0, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
      sample(); chk("fp_m1_granted", 32'(m1_waitrequest), 32'h0); tick();
`endif
      set_m(0, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
      set_m(1, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
      sample(); tick();

      // Reset in the cycle after a read is accepted
      set_m(0, 1'b1, 1'b0, 10'h3FF, 4'hF, 32'h0); sample(); tick();
      set_m(0, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
      reset_n = 1'b0; model_reset(); #1;
      chk("mid_rst_m0_rdv", 32'(m0_readdatavalid), 32'h0);
      chk("mid_rst_cs", 32'(mem_chipselect), 32'h0);
      chk("mid_rst_m0_wait", 32'(m0_waitrequest), 32'h1);
      chk("mid_rst_reset_req", 32'(mem_reset_req), 32'h1);
      sample(); tick(); sample(); tick();
      reset_n = 1'b1;
      set_m(0, 1'b1, 1'b0, 10'h001, 4'hF, 32'h0);
      set_m(1, 1'b1, 1'b0, 10'h002, 4'hF, 32'h0);
      sample(); tick(); sample(); tick();
      sample(); chk("post_rst_m0_first", 32'(m0_waitrequest), 32'h0); tick();
      set_m(0, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
      set_m(1, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
      sample(); tick();

      // Random traffic; a stalled master holds its request
      act0 = 1'b0; act1 = 1'b0;
      for (int c = 0; c < 600; c++) begin
         if (!act0 && $urandom_range(0, 9) < 7) begin
            act0 = 1'b1;
            if ($urandom_range(0, 1) == 1)
               set_m(0, 1'b1, 1'b0, 10'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom);
            else
               set_m(0, 1'b0, 1'b1, 10'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom);
         end
         if (!act1 && $urandom_range(0, 9) < 7) begin
            act1 = 1'b1;
            if ($urandom_range(0, 1) == 1)
               set_m(1, 1'b1, 1'b0, 10'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom);
            else
               set_m(1, 1'b0, 1'b1, 10'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom);
         end
         sample();
         tick();
         if (exp_win == 0) begin act0 = 1'b0; m0_read = 1'b0; m0_write = 1'b0; end
         if (exp_win == 1) begin act1 = 1'b0; m1_read = 1'b0; m1_write = 1'b0; end
      end
      set_m(0, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
      set_m(1, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
      sample(); tick();

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule
